// File: rtl/mainmem_resp_4c.sv
// Main-memory responder behind the cache arbiter: writes commit at the accept
// edge, reads return a snapshot of the word LATENCY cycles later, in order.
module mainmem_resp_4c #(
    parameter int LATENCY = 4,
    parameter int AW      = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic [3:0]  outstanding
);

    localparam int DEPTH = 1 << AW;

    logic [15:0]        mem [DEPTH];
    logic [AW-1:0]      word_idx;
    logic               read_accept;
    logic               write_accept;
    logic [LATENCY-1:0] stage_valid;
    logic [15:0]        stage_data [LATENCY];
    logic               addr_unused;

    // addr[0] (and any bits above AW when AW is narrowed) never reach the array.
    assign addr_unused  = ^addr;
    assign word_idx     = addr[AW:1];
    assign read_accept  = enable & ~wr;
    assign write_accept = enable & wr;

    // The array has no reset so preloaded contents survive; writes are still gated by reset.
    always_ff @(posedge clk) begin
        if (rst_n && write_accept) begin
            mem[word_idx] <= data_in;
        end
    end

    // Each stage keeps its data through bubbles, so the last stage holds the last response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_valid <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                stage_data[i] <= 16'h0000;
            end
        end else begin
            stage_valid[0] <= read_accept;
            if (read_accept) begin
                stage_data[0] <= mem[word_idx];
            end
            for (int i = 1; i < LATENCY; i++) begin
                stage_valid[i] <= stage_valid[i-1];
                if (stage_valid[i-1]) begin
                    stage_data[i] <= stage_data[i-1];
                end
            end
        end
    end

    assign data_valid = stage_valid[LATENCY-1];
    assign data_out   = stage_data[LATENCY-1];

    // A response retires at the edge where the arbiter samples data_valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outstanding <= 4'd0;
        end else begin
            case ({read_accept, data_valid})
                2'b10:   outstanding <= outstanding + 4'd1;
                2'b01:   outstanding <= outstanding - 4'd1;
                default: outstanding <= outstanding;
            endcase
        end
    end

endmodule

// File: doc/mainmem_resp_4c.md
# mainmem_resp_4c

Multicycle main-memory responder sitting behind the cache arbiter: the slave end of the arbiter's main-memory interface (addr / write data / wr / read data / data_valid). It accepts at most one word request per cycle, commits writes immediately, and returns each read's data with a fixed `LATENCY`-cycle delay through an internal valid/data pipeline. This keeps the arbiter's cache-fill FSMs free to issue back-to-back line-fill reads.

## Interface
- `LATENCY`, 4, cycles from request acceptance to `data_valid`; legal range 1..8.
- `AW`, 15, word-address width; the array holds 2^AW 16-bit words.
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `enable`  in  1  request strobe; a request is accepted on every edge where `enable`=1.
- `wr`  in  1  1 = write request, 0 = read request; ignored when `enable`=0.
- `addr`  in  16  byte address; the word index is `addr[AW:1]`, and `addr[0]` is ignored.
- `data_in`  in  16  write data, sampled with the write request.
- `data_out`  out  16  read data; meaningful only while `data_valid`=1.
- `data_valid`  out  1  read response strobe, high for exactly one cycle per read.
- `outstanding`  out  4  number of accepted reads not yet returned.

## Operation
- **Request acceptance:** every cycle with `enable`=1 is one accepted request. There is no backpressure and no stall output.
- **Write** (`enable`=1, `wr`=1): `mem[addr[AW:1]]` is updated at that edge. No response is generated.
- **Read** (`enable`=1, `wr`=0):
  - The array is read at the accept edge. The result reflects all writes accepted in strictly earlier cycles.
  - The word enters pipeline stage 1 with valid=1.
  - Each edge shifts the stages; stage `LATENCY` drives `data_out` / `data_valid`.
- **Ordering:** responses return in request order. Each response is a snapshot taken at read acceptance, so a later write to the same address never alters an in-flight read.
- **Pipeline bubbles:** stages for non-read cycles carry valid=0. While `data_valid`=0, `data_out` holds its last driven value.
- **`outstanding`:**
  - +1 on read accept and −1 on a response edge; simultaneous accept and response leaves it unchanged.
  - Never exceeds `LATENCY`.
- **Reset** (`rst_n`=0 at an edge):
  - All pipeline valids clear, `data_valid`=0, `data_out`=16'h0000, `outstanding`=0.
  - In-flight reads are dropped and no response is ever produced for them.
  - Array contents are not cleared; preloaded program/data survive.
  - A request presented during reset is ignored, and a write is not committed.
- **Address wrap:** `addr` bits above `AW` are ignored, so addresses alias modulo 2^(AW+1) bytes.

## Timing
- Read accepted at edge N → `data_valid`=1 and `data_out` valid during the cycle after edge N+`LATENCY`−1, i.e. sampled by the arbiter at edge N+`LATENCY`.
- Back-to-back reads on edges N..N+3 → responses on consecutive cycles with no gaps. Full throughput is one word per cycle.
- Write at edge N, read of the same word at edge N+1 → the read returns the new data.
- `outstanding` is registered and updates at the same edge as the event it counts.

## Test plan
- **Write then read (default `LATENCY`=4):**
  - Stimulus: write 16'hBEEF to addr 16'h0010 at edge 0, then read addr 16'h0010 at edge 1.
  - Response: `data_valid` only in the cycle after edge 4, with `data_out`=16'hBEEF. `outstanding` reads 1,1,1,1 then 0.
- **Burst read:**
  - Stimulus: preload words at 0x0100, 0x0102, 0x0104, 0x0106 with 1, 2, 3, 4; read them on 4 consecutive edges.
  - Response: `data_valid` high for 4 consecutive cycles with `data_out` = 1, 2, 3, 4 in order. `outstanding` peaks at 4.
- **In-flight snapshot:**
  - Stimulus: word 0x0020 holds 16'h1111; read it at edge 0, then write 16'h2222 to it at edge 1.
  - Response: the edge-0 read returns 16'h1111, and a read issued at edge 2 returns 16'h2222.
- **Reset mid-flight:**
  - Stimulus: read at edge 0, drive `rst_n`=0 at edge 2.
  - Response: `data_valid` never asserts for that read, and `outstanding`=0, `data_out`=0 after edge 2. A word written before reset still reads back intact afterwards.
- **Odd address and idle:**
  - Stimulus: write 16'hA5A5 to 0x0031, read 0x0030; separately hold `enable`=0 with `wr`=1.
  - Response: the read returns 16'hA5A5. The idle cycles leave the array unchanged and produce no `data_valid`.
- **Reset write suppression:**
  - Stimulus: present `enable`=1, `wr`=1, data 16'h7777 while `rst_n`=0.
  - Response: the later read returns the prior contents, not 16'h7777.
